// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared floor/direction types and helpers for the elevator datapath
// Contents:
//   NUM_FLOORS, FLOOR_W      floor count and floor index width
//   floor_t, floor_vec_t     floor index and per-floor bit vector
//   dir_e                    controller committed direction encodings
//   UP_LIVE, DOWN_LIVE       which hall buttons physically exist
//   bit_count, onehot_index, above_mask, below_mask
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  typedef logic [FLOOR_W-1:0]    floor_t;
  typedef logic [NUM_FLOORS-1:0] floor_vec_t;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  // No up button at the top floor, no down button at the bottom floor.
  localparam floor_vec_t UP_LIVE   = 4'b0111;
  localparam floor_vec_t DOWN_LIVE = 4'b1110;

  function automatic logic [2:0] bit_count(floor_vec_t v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_FLOORS; i++) c = c + 3'(v[i]);
    return c;
  endfunction

  // Only meaningful when v is one-hot.
  function automatic floor_t onehot_index(floor_vec_t v);
    floor_t idx;
    idx = '0;
    for (int i = 0; i < NUM_FLOORS; i++) if (v[i]) idx = floor_t'(i);
    return idx;
  endfunction

  function automatic floor_vec_t above_mask(floor_t fl);
    floor_vec_t m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(fl));
    return m;
  endfunction

  function automatic floor_vec_t below_mask(floor_t fl);
    floor_vec_t m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(fl));
    return m;
  endfunction

endpackage

// File: rtl/elevator_call_register_if.sv
// rtl/elevator_call_register_if.sv - button/sensor inputs and pending-call outputs of the call register
// Signals:
//   F, U, D      cabin / hall-up / hall-down buttons, bit i = floor i+1
//   S            one-hot floor sensors (all-zero between floors)
//   OPEN, DIR    door-open indication and committed direction from the controller
//   CALL_F/U/D   pending calls
//   FLOOR        last valid floor; AT_FLOOR / SERR sensor status
//   ANY_ABOVE/BELOW/HERE  pending-call summaries relative to FLOOR
// Modports: master drives buttons/sensors/controller status, slave is the call register.
interface elevator_call_register_if;
  import elevator_pkg::*;

  floor_vec_t F;
  floor_vec_t U;
  floor_vec_t D;
  floor_vec_t S;
  logic       OPEN;
  logic [1:0] DIR;

  floor_vec_t CALL_F;
  floor_vec_t CALL_U;
  floor_vec_t CALL_D;
  floor_t     FLOOR;
  logic       AT_FLOOR;
  logic       SERR;
  logic       ANY_ABOVE;
  logic       ANY_BELOW;
  logic       ANY_HERE;

  modport master (
    output F, U, D, S, OPEN, DIR,
    input  CALL_F, CALL_U, CALL_D, FLOOR, AT_FLOOR, SERR,
    input  ANY_ABOVE, ANY_BELOW, ANY_HERE
  );

  modport slave (
    input  F, U, D, S, OPEN, DIR,
    output CALL_F, CALL_U, CALL_D, FLOOR, AT_FLOOR, SERR,
    output ANY_ABOVE, ANY_BELOW, ANY_HERE
  );

endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-button debounce counter with arm bit and single-cycle latch pulse
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   btn_i    raw button level
//   latch_o  high in the cycle whose edge accepts the press (combinational)
module button_debounce #(
  parameter int DEBOUNCE = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic latch_o
);

  localparam logic [3:0] DEB_C = 4'(DEBOUNCE);

  logic [3:0] cnt_q, cnt_d;
  logic       arm_q, arm_d;

  // The pulse is raised in the same cycle the counter is about to reach
  // DEBOUNCE, so the pending bit sets on the very edge that completes the
  // debounce window.
  always_comb begin
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    latch_o = 1'b0;
    if (btn_i) begin
      if (cnt_q != DEB_C) cnt_d = cnt_q + 4'd1;
      if ((cnt_d == DEB_C) && arm_q) begin
        latch_o = 1'b1;
        arm_d   = 1'b0;
      end
    end else begin
      cnt_d = '0;
      arm_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      arm_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      arm_q <= arm_d;
    end
  end

endmodule

// File: rtl/elevator_call_register.sv
// rtl/elevator_call_register.sv - debounced call latching, floor tracking and service clear
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous active-low reset
//   bus    elevator_call_register_if.slave (buttons, sensors, controller status in;
//          pending calls, floor, sensor status and summaries out)
module elevator_call_register
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  elevator_call_register_if.slave   bus
);

  floor_vec_t set_f, set_u, set_d;
  floor_vec_t clr_f, clr_u, clr_d;
  floor_vec_t call_f_q, call_u_q, call_d_q;
  floor_vec_t call_f_d, call_u_d, call_d_d;
  floor_t     floor_q, floor_d;
  floor_t     s_idx;
  logic [2:0] s_count;
  logic       at_floor;
  logic       serve;
  floor_vec_t all_calls;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_cab
    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk_i  (CLK),
      .rst_ni (RESET),
      .btn_i  (bus.F[i]),
      .latch_o(set_f[i])
    );
  end

  for (genvar i = 0; i < NUM_FLOORS - 1; i++) begin : g_up
    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk_i  (CLK),
      .rst_ni (RESET),
      .btn_i  (bus.U[i]),
      .latch_o(set_u[i])
    );
  end

  for (genvar i = 1; i < NUM_FLOORS; i++) begin : g_dn
    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk_i  (CLK),
      .rst_ni (RESET),
      .btn_i  (bus.D[i]),
      .latch_o(set_d[i])
    );
  end

  // Top-floor up and bottom-floor down buttons do not exist; their wires are tied off.
  assign set_u[NUM_FLOORS-1] = bus.U[NUM_FLOORS-1] & 1'b0;
  assign set_d[0]            = bus.D[0] & 1'b0;

  assign s_count  = bit_count(bus.S);
  assign at_floor = (s_count == 3'd1);
  assign s_idx    = onehot_index(bus.S);
  // A multi-hot sensor is never at_floor, so it can neither move FLOOR nor clear.
  assign serve    = bus.OPEN & at_floor;

  always_comb begin
    clr_f   = '0;
    clr_u   = '0;
    clr_d   = '0;
    floor_d = floor_q;
    if (at_floor) floor_d = s_idx;
    if (serve) begin
      clr_f[s_idx] = 1'b1;
      // Moving down does not serve the up call and vice versa; idle (or 11) serves both.
      if (bus.DIR != DIR_DOWN) clr_u[s_idx] = 1'b1;
      if (bus.DIR != DIR_UP)   clr_d[s_idx] = 1'b1;
    end
    // Clear is applied after set so a press at a serving door is consumed.
    call_f_d = (call_f_q | set_f) & ~clr_f;
    call_u_d = (call_u_q | set_u) & ~clr_u & UP_LIVE;
    call_d_d = (call_d_q | set_d) & ~clr_d & DOWN_LIVE;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      call_f_q <= '0;
      call_u_q <= '0;
      call_d_q <= '0;
      floor_q  <= '0;
    end else begin
      call_f_q <= call_f_d;
      call_u_q <= call_u_d;
      call_d_q <= call_d_d;
      floor_q  <= floor_d;
    end
  end

  assign all_calls = call_f_q | call_u_q | call_d_q;

  assign bus.CALL_F    = call_f_q;
  assign bus.CALL_U    = call_u_q;
  assign bus.CALL_D    = call_d_q;
  assign bus.FLOOR     = floor_q;
  assign bus.AT_FLOOR  = at_floor;
  assign bus.SERR      = (s_count > 3'd1);
  assign bus.ANY_ABOVE = |(all_calls & above_mask(floor_q));
  assign bus.ANY_BELOW = |(all_calls & below_mask(floor_q));
  assign bus.ANY_HERE  = all_calls[floor_q];

endmodule

// File: tb/tb_elevator_call_register.sv
// tb/tb_elevator_call_register.sv - self-checking bench for elevator_call_register
module tb_elevator_call_register;

  localparam int DEB = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  elevator_call_register_if bus();

  elevator_call_register #(.DEBOUNCE(DEB)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a button latches once per high run, on the run's DEB-th edge.
  int run_f[4], run_u[4], run_d[4];
  bit pf[4], pu[4], pd[4];
  int mfloor;

  function automatic int ones(logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      run_f[i] = 0; run_u[i] = 0; run_d[i] = 0;
      pf[i] = 0; pu[i] = 0; pd[i] = 0;
    end
    mfloor = 0;
  endfunction

  function automatic void model_edge();
    int k;
    if (!RESET) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      run_f[i] = bus.F[i] ? run_f[i] + 1 : 0;
      if (run_f[i] == DEB) pf[i] = 1;
      if (i < 3) begin
        run_u[i] = bus.U[i] ? run_u[i] + 1 : 0;
        if (run_u[i] == DEB) pu[i] = 1;
      end
      if (i > 0) begin
        run_d[i] = bus.D[i] ? run_d[i] + 1 : 0;
        if (run_d[i] == DEB) pd[i] = 1;
      end
    end
    if (ones(bus.S) == 1) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (bus.S[i]) k = i;
      if (bus.OPEN) begin
        pf[k] = 0;
        if (bus.DIR != 2'b10) pu[k] = 0;
        if (bus.DIR != 2'b01) pd[k] = 0;
      end
      mfloor = k;
    end
  endfunction

  // {CALL_F, CALL_U, CALL_D, FLOOR, AT_FLOOR, SERR, ANY_ABOVE, ANY_BELOW, ANY_HERE}
  function automatic logic [18:0] expected();
    logic [3:0] ef, eu, ed;
    logic above, below, here;
    int n;
    above = 0; below = 0; here = 0;
    for (int i = 0; i < 4; i++) begin
      ef[i] = pf[i]; eu[i] = pu[i]; ed[i] = pd[i];
      if (pf[i] || pu[i] || pd[i]) begin
        if (i > mfloor) above = 1;
        else if (i < mfloor) below = 1;
        else here = 1;
      end
    end
    n = ones(bus.S);
    return {ef, eu, ed, 2'(mfloor), n == 1, n > 1, above, below, here};
  endfunction

  function automatic logic [18:0] observed();
    return {bus.CALL_F, bus.CALL_U, bus.CALL_D, bus.FLOOR, bus.AT_FLOOR, bus.SERR,
            bus.ANY_ABOVE, bus.ANY_BELOW, bus.ANY_HERE};
  endfunction

  task automatic drive(input logic [3:0] f, input logic [3:0] u, input logic [3:0] d,
                       input logic [3:0] s, input logic open, input logic [1:0] dir);
    bus.F = f; bus.U = u; bus.D = d; bus.S = s; bus.OPEN = open; bus.DIR = dir;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    tick();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    drive(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    #1;
    if (observed() !== 19'd0) begin
      miscompares++; $display("FAIL reset_async: got %b want %b", observed(), 19'd0);
    end
    vectors++;
    repeat (3) begin
      tick();
      if (observed() !== 19'd0) begin
        miscompares++; $display("FAIL reset_hold: got %b want %b", observed(), 19'd0);
      end
      vectors++;
    end
    RESET = 1'b1;
    tick();
    if (observed() !== expected()) begin
      miscompares++; $display("FAIL reset_release1: got %b want %b", observed(), expected());
    end
    vectors++;
    tick();
    if (bus.CALL_F !== 4'b1111) begin
      miscompares++; $display("FAIL reset_release2: CALL_F got %b want %b", bus.CALL_F, 4'b1111);
    end
    vectors++;
    if (observed() !== expected()) begin
      miscompares++; $display("FAIL reset_release2_model: got %b want %b", observed(), expected());
    end
    vectors++;
  endtask

  task automatic test_debounce();
    do_reset();
    drive(4'h0, 4'b0010, 4'h0, 4'h0, 1'b0, 2'b00);
    tick();
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    tick();
    if (bus.CALL_U !== 4'b0000) begin
      miscompares++; $display("FAIL debounce_glitch: CALL_U got %b want %b", bus.CALL_U, 4'b0000);
    end
    vectors++;
    drive(4'h0, 4'b0010, 4'h0, 4'h0, 1'b0, 2'b00);
    tick();
    if (bus.CALL_U !== 4'b0000) begin
      miscompares++; $display("FAIL debounce_edge1: CALL_U got %b want %b", bus.CALL_U, 4'b0000);
    end
    vectors++;
    tick();
    if (bus.CALL_U !== 4'b0010) begin
      miscompares++; $display("FAIL debounce_edge2: CALL_U got %b want %b", bus.CALL_U, 4'b0010);
    end
    vectors++;
    // Held press: latch, serve it away, keep holding; it must not come back.
    drive(4'h0, 4'b0010, 4'h0, 4'b0010, 1'b1, 2'b00);
    tick();
    drive(4'h0, 4'b0010, 4'h0, 4'h0, 1'b0, 2'b00);
    repeat (17) begin
      tick();
      if (observed() !== expected()) begin
        miscompares++; $display("FAIL debounce_hold: got %b want %b", observed(), expected());
      end
      vectors++;
    end
    if (bus.CALL_U !== 4'b0000) begin
      miscompares++; $display("FAIL debounce_once: CALL_U got %b want %b", bus.CALL_U, 4'b0000);
    end
    vectors++;
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    tick();
  endtask

  task automatic test_floor();
    do_reset();
    drive(4'b1000, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    tick(); tick();
    drive(4'h0, 4'h0, 4'h0, 4'b0010, 1'b0, 2'b00);
    tick();
    drive(4'h0, 4'h0, 4'h0, 4'b0000, 1'b0, 2'b00);
    tick();
    if ({bus.FLOOR, bus.AT_FLOOR, bus.ANY_ABOVE, bus.ANY_BELOW} !== 5'b01_0_1_0) begin
      miscompares++;
      $display("FAIL floor_hold: FLOOR/AT/ABOVE/BELOW got %b want %b",
               {bus.FLOOR, bus.AT_FLOOR, bus.ANY_ABOVE, bus.ANY_BELOW}, 5'b01_0_1_0);
    end
    vectors++;
    drive(4'h0, 4'h0, 4'h0, 4'b0101, 1'b1, 2'b00);
    tick();
    if ({bus.FLOOR, bus.AT_FLOOR, bus.SERR} !== 4'b01_0_1) begin
      miscompares++;
      $display("FAIL floor_serr: FLOOR/AT/SERR got %b want %b",
               {bus.FLOOR, bus.AT_FLOOR, bus.SERR}, 4'b01_0_1);
    end
    vectors++;
    if (observed() !== expected()) begin
      miscompares++; $display("FAIL floor_model: got %b want %b", observed(), expected());
    end
    vectors++;
  endtask

  task automatic test_dir_clear();
    do_reset();
    drive(4'b0100, 4'b0100, 4'b0100, 4'h0, 1'b0, 2'b00);
    tick(); tick();
    drive(4'h0, 4'h0, 4'h0, 4'b0100, 1'b1, 2'b01);
    tick();
    if ({bus.CALL_F[2], bus.CALL_U[2], bus.CALL_D[2]} !== 3'b001) begin
      miscompares++;
      $display("FAIL dir_up_clear: F/U/D[2] got %b want %b",
               {bus.CALL_F[2], bus.CALL_U[2], bus.CALL_D[2]}, 3'b001);
    end
    vectors++;
    drive(4'h0, 4'h0, 4'h0, 4'b0100, 1'b1, 2'b10);
    tick();
    if ({bus.CALL_F[2], bus.CALL_U[2], bus.CALL_D[2]} !== 3'b000) begin
      miscompares++;
      $display("FAIL dir_down_clear: F/U/D[2] got %b want %b",
               {bus.CALL_F[2], bus.CALL_U[2], bus.CALL_D[2]}, 3'b000);
    end
    vectors++;
    if (observed() !== expected()) begin
      miscompares++; $display("FAIL dir_model: got %b want %b", observed(), expected());
    end
    vectors++;
  endtask

  task automatic test_service_press();
    do_reset();
    drive(4'b0010, 4'h0, 4'h0, 4'b0010, 1'b1, 2'b00);
    repeat (3) begin
      tick();
      if (bus.CALL_F[1] !== 1'b0) begin
        miscompares++; $display("FAIL service_consume: CALL_F[1] got %b want %b", bus.CALL_F[1], 1'b0);
      end
      vectors++;
    end
    drive(4'h0, 4'h0, 4'h0, 4'b0010, 1'b0, 2'b00);
    tick();
    drive(4'b0010, 4'h0, 4'h0, 4'b0010, 1'b0, 2'b00);
    repeat (3) tick();
    if (bus.CALL_F[1] !== 1'b1) begin
      miscompares++; $display("FAIL service_closed: CALL_F[1] got %b want %b", bus.CALL_F[1], 1'b1);
    end
    vectors++;
    if (observed() !== expected()) begin
      miscompares++; $display("FAIL service_model: got %b want %b", observed(), expected());
    end
    vectors++;
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(4'b1000, 4'b0001, 4'h0, 4'h0, 1'b0, 2'b00);
    tick(); tick();
    drive(4'h0, 4'h0, 4'h0, 4'b1000, 1'b0, 2'b00);
    tick();
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    tick();
    if ({bus.FLOOR, bus.CALL_F, bus.CALL_U} !== 10'b11_1000_0001) begin
      miscompares++;
      $display("FAIL areset_pre: FLOOR/CALL_F/CALL_U got %b want %b",
               {bus.FLOOR, bus.CALL_F, bus.CALL_U}, 10'b11_1000_0001);
    end
    vectors++;
    #2 RESET = 1'b0;
    #1;
    if (observed() !== 19'd0) begin
      miscompares++; $display("FAIL areset_mid: got %b want %b", observed(), 19'd0);
    end
    vectors++;
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    if (observed() !== expected()) begin
      miscompares++; $display("FAIL areset_after: got %b want %b", observed(), expected());
    end
    vectors++;
  endtask

  task automatic test_random();
    logic [3:0] f, u, d, s;
    logic       open;
    logic [1:0] dir;
    int         r;
    do_reset();
    f = 0; u = 0; d = 0;
    for (int n = 0; n < 600; n++) begin
      f ^= 4'($urandom & $urandom);
      u ^= 4'($urandom & $urandom);
      d ^= 4'($urandom & $urandom);
      r = $urandom_range(0, 9);
      if (r < 3)      s = 4'b0000;
      else if (r < 9) s = 4'b0001 << $urandom_range(0, 3);
      else            s = 4'b0011 << $urandom_range(0, 2);
      open = ($urandom_range(0, 2) == 0);
      dir  = 2'($urandom_range(0, 3));
      drive(f, u, d, s, open, dir);
      tick();
      if (observed() !== expected()) begin
        miscompares++; $display("FAIL random[%0d]: got %b want %b", n, observed(), expected());
      end
      vectors++;
    end
  endtask

  initial begin
    model_reset();
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    test_reset();
    test_debounce();
    test_floor();
    test_dir_clear();
    test_service_press();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
